// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults and the bit-reversal helper
// used by the radix-2 DIT FFT datapath.
package fft_pkg;

    localparam int NBD_DEF       = 8;
    localparam int NPTS_LOG2_DEF = 4;
    localparam int BITREV_MAXW   = 16;

    // Reverse the low w bits of v; result is right-aligned.
    function automatic logic [BITREV_MAXW-1:0] bitrev(
        input logic [BITREV_MAXW-1:0] v,
        input int                     w
    );
        logic [BITREV_MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAXW; i++) begin
            r[i] = v[BITREV_MAXW-1-i];
        end
        return r >> (BITREV_MAXW - w);
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two banks of 2**AW words, one write port and
// two asynchronous read ports (x/y words) into the draining bank.
module fft_pingpong_ram #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic          i_wbank,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_rbank,
    input  logic [AW-1:0] i_raddr_x,
    input  logic [AW-1:0] i_raddr_y,
    output logic [DW-1:0] o_rdata_x,
    output logic [DW-1:0] o_rdata_y
);

    logic [DW-1:0] mem_q [2**(AW+1)];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[{i_wbank, i_waddr}] <= i_wdata;
        end
    end

    assign o_rdata_x = mem_q[{i_rbank, i_raddr_x}];
    assign o_rdata_y = mem_q[{i_rbank, i_raddr_y}];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// fft_bitrev_buffer: natural-order samples in, bit-reversed pairs out.
// Define FFT_BITREV_BYPASS_EN to add i_bypass (natural-order frames).
module fft_bitrev_buffer
    import fft_pkg::*;
#(
    parameter int NBD       = NBD_DEF,
    parameter int NPTS_LOG2 = NPTS_LOG2_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
`ifdef FFT_BITREV_BYPASS_EN
    input  logic                  i_bypass,
`endif
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic signed [NBD-1:0] i_real,
    input  logic signed [NBD-1:0] i_imag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic signed [NBD-1:0] o_x_real,
    output logic signed [NBD-1:0] o_x_imag,
    output logic signed [NBD-1:0] o_y_real,
    output logic signed [NBD-1:0] o_y_imag,
    output logic                  o_frame_last
);

    localparam int N  = 2**NPTS_LOG2;
    localparam int L  = NPTS_LOG2;
    localparam int PW = (L > 1) ? L - 1 : 1;
    localparam int DW = 2 * NBD;

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [L-1:0]  wr_idx_q, wr_idx_d;
    logic [PW-1:0] rd_pair_q, rd_pair_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [DW-1:0] x_q, x_d, y_q, y_d;

    logic          wr_en, wr_last, rd_last, load, byp_now;
    logic [L-1:0]  waddr, raddr_x, raddr_y;
    logic [DW-1:0] rdata_x, rdata_y;

    assign o_ready = !full_q[wr_bank_q] && !i_rst;
    assign wr_en   = i_valid && o_ready;
    assign wr_last = wr_idx_q == L'(N - 1);
    assign rd_last = rd_pair_q == PW'(N / 2 - 1);
    assign load    = full_q[rd_bank_q] && (!valid_q || i_ready);
    assign raddr_x = L'({rd_pair_q, 1'b0});
    assign raddr_y = raddr_x | L'(1);

`ifdef FFT_BITREV_BYPASS_EN
    logic byp_q, byp_d;

    // Mode is latched with the first sample and held for the frame.
    assign byp_now = (wr_idx_q == '0) ? i_bypass : byp_q;
    assign byp_d   = (wr_en && wr_idx_q == '0) ? i_bypass : byp_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) byp_q <= 1'b0;
        else       byp_q <= byp_d;
    end
`else
    assign byp_now = 1'b0;
`endif

    assign waddr = byp_now ? wr_idx_q
                           : L'(bitrev(BITREV_MAXW'(wr_idx_q), L));

    fft_pingpong_ram #(
        .DW(DW),
        .AW(L)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we     (wr_en),
        .i_wbank  (wr_bank_q),
        .i_waddr  (waddr),
        .i_wdata  ({i_real, i_imag}),
        .i_rbank  (rd_bank_q),
        .i_raddr_x(raddr_x),
        .i_raddr_y(raddr_y),
        .o_rdata_x(rdata_x),
        .o_rdata_y(rdata_y)
    );

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_bank_d = rd_bank_q;
        rd_pair_d = rd_pair_q;
        valid_d   = valid_q;
        last_d    = last_q;
        x_d       = x_q;
        y_d       = y_q;

        if (wr_en) begin
            wr_idx_d = wr_idx_q + L'(1);
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // Read side clears a different bank than the write side sets.
        if (load) begin
            valid_d   = 1'b1;
            last_d    = rd_last;
            x_d       = rdata_x;
            y_d       = rdata_y;
            rd_pair_d = rd_pair_q + PW'(1);
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_pair_d         = '0;
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_pair_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_bank_q <= rd_bank_d;
            rd_pair_q <= rd_pair_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_frame_last = last_q;
    assign o_x_real     = x_q[DW-1:NBD];
    assign o_x_imag     = x_q[NBD-1:0];
    assign o_y_real     = y_q[DW-1:NBD];
    assign o_y_imag     = y_q[NBD-1:0];

endmodule
